// File: rtl/wb_stage_if.sv
// Write-back stage bus: MEM-stage result, data-memory read data, MDU result
// handshake and the register-file write port.
interface wb_stage_if #(
    parameter int unsigned REG_AW = 5
);
    logic              flush;
    logic              mem_valid;
    logic              mem_wreg;
    logic [REG_AW-1:0] mem_wd;
    logic [31:0]       mem_wdata;
    logic              mem_is_load;
    logic [2:0]        mem_load_type;
    logic [1:0]        mem_addr_lo;
    logic [31:0]       dmem_rdata;
    logic              mdu_valid;
    logic [REG_AW-1:0] mdu_wd;
    logic [31:0]       mdu_wdata;
    logic              mdu_ready;
    logic              stall_req;
    logic              wr_en;
    logic [REG_AW-1:0] wraddr;
    logic [31:0]       wrdata;

    modport master (
        output flush, mem_valid, mem_wreg, mem_wd, mem_wdata, mem_is_load,
               mem_load_type, mem_addr_lo, dmem_rdata, mdu_valid, mdu_wd, mdu_wdata,
        input  mdu_ready, stall_req, wr_en, wraddr, wrdata
    );

    modport slave (
        input  flush, mem_valid, mem_wreg, mem_wd, mem_wdata, mem_is_load,
               mem_load_type, mem_addr_lo, dmem_rdata, mdu_valid, mdu_wd, mdu_wdata,
        output mdu_ready, stall_req, wr_en, wraddr, wrdata
    );
endinterface

// File: rtl/wb_stage.sv
// Write-back stage: MEM/WB register, big-endian load extraction and a one-entry
// MDU result buffer sharing the register-file write port. WB_STARVE_EN adds the starvation stall.
module wb_stage #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned REG_AW       = 5
) (
    input logic   clk,
    input logic   rst,
    wb_stage_if.slave bus
);
    localparam int unsigned AGE_W = 3;

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 7) begin : g_bad_limit
        $error("wb_stage: STARVE_LIMIT must be in 1..7");
    end

    logic              wb_valid_q,     wb_valid_d;
    logic              wb_wreg_q,      wb_wreg_d;
    logic [REG_AW-1:0] wb_wd_q,        wb_wd_d;
    logic [31:0]       wb_wdata_q,     wb_wdata_d;
    logic              wb_is_load_q,   wb_is_load_d;
    logic [2:0]        wb_load_type_q, wb_load_type_d;
    logic [1:0]        wb_addr_lo_q,   wb_addr_lo_d;
    logic              buf_valid_q,    buf_valid_d;
    logic [REG_AW-1:0] buf_wd_q,       buf_wd_d;
    logic [31:0]       buf_wdata_q,    buf_wdata_d;

    logic        stall;
    logic        pipe_sel;
    logic        buf_sel;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] result;

    assign pipe_sel = wb_valid_q & wb_wreg_q;
    assign buf_sel  = buf_valid_q & ~pipe_sel;

`ifdef WB_STARVE_EN
    logic [AGE_W-1:0] age_q, age_d;

    assign stall = buf_valid_q & (age_q >= AGE_W'(STARVE_LIMIT));

    // Age counts cycles a full buffer is passed over by the pipeline write.
    always_comb begin
        age_d = age_q;
        if (!buf_valid_q || buf_sel) begin
            age_d = '0;
        end else if (age_q != {AGE_W{1'b1}}) begin
            age_d = age_q + AGE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) age_q <= '0;
        else     age_q <= age_d;
    end
`else
    assign stall = 1'b0;
`endif

    // Big-endian byte/halfword selection and extension.
    always_comb begin
        byte_sel = bus.dmem_rdata[31:24];
        case (wb_addr_lo_q)
            2'd1:    byte_sel = bus.dmem_rdata[23:16];
            2'd2:    byte_sel = bus.dmem_rdata[15:8];
            2'd3:    byte_sel = bus.dmem_rdata[7:0];
            default: byte_sel = bus.dmem_rdata[31:24];
        endcase
        half_sel = wb_addr_lo_q[1] ? bus.dmem_rdata[15:0] : bus.dmem_rdata[31:16];
        result   = bus.dmem_rdata;
        case (wb_load_type_q)
            3'd1:    result = {{24{byte_sel[7]}}, byte_sel};
            3'd2:    result = {24'd0, byte_sel};
            3'd3:    result = {{16{half_sel[15]}}, half_sel};
            3'd4:    result = {16'd0, half_sel};
            default: result = bus.dmem_rdata;
        endcase
        if (!wb_is_load_q) result = wb_wdata_q;
    end

    // Next-state: MEM/WB capture (bubble on stall) and buffer load/drain.
    always_comb begin
        wb_valid_d     = 1'b0;
        wb_wreg_d      = wb_wreg_q;
        wb_wd_d        = wb_wd_q;
        wb_wdata_d     = wb_wdata_q;
        wb_is_load_d   = wb_is_load_q;
        wb_load_type_d = wb_load_type_q;
        wb_addr_lo_d   = wb_addr_lo_q;
        buf_valid_d    = buf_valid_q;
        buf_wd_d       = buf_wd_q;
        buf_wdata_d    = buf_wdata_q;
        if (!stall) begin
            wb_valid_d     = bus.mem_valid & ~bus.flush;
            wb_wreg_d      = bus.mem_wreg;
            wb_wd_d        = bus.mem_wd;
            wb_wdata_d     = bus.mem_wdata;
            wb_is_load_d   = bus.mem_is_load;
            wb_load_type_d = bus.mem_load_type;
            wb_addr_lo_d   = bus.mem_addr_lo;
        end
        if (buf_sel) begin
            buf_valid_d = 1'b0;
        end else if (bus.mdu_valid && !buf_valid_q) begin
            buf_valid_d = 1'b1;
            buf_wd_d    = bus.mdu_wd;
            buf_wdata_d = bus.mdu_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid_q     <= 1'b0;
            wb_wreg_q      <= 1'b0;
            wb_wd_q        <= '0;
            wb_wdata_q     <= '0;
            wb_is_load_q   <= 1'b0;
            wb_load_type_q <= '0;
            wb_addr_lo_q   <= '0;
            buf_valid_q    <= 1'b0;
            buf_wd_q       <= '0;
            buf_wdata_q    <= '0;
        end else begin
            wb_valid_q     <= wb_valid_d;
            wb_wreg_q      <= wb_wreg_d;
            wb_wd_q        <= wb_wd_d;
            wb_wdata_q     <= wb_wdata_d;
            wb_is_load_q   <= wb_is_load_d;
            wb_load_type_q <= wb_load_type_d;
            wb_addr_lo_q   <= wb_addr_lo_d;
            buf_valid_q    <= buf_valid_d;
            buf_wd_q       <= buf_wd_d;
            buf_wdata_q    <= buf_wdata_d;
        end
    end

    // Write port: pipeline first, then buffer; r0 writes are consumed but suppressed.
    always_comb begin
        bus.wr_en     = 1'b0;
        bus.wraddr    = '0;
        bus.wrdata    = '0;
        bus.mdu_ready = 1'b0;
        bus.stall_req = 1'b0;
        if (!rst) begin
            bus.mdu_ready = ~buf_valid_q;
            bus.stall_req = stall;
            if (pipe_sel) begin
                bus.wr_en  = (wb_wd_q != '0);
                bus.wraddr = wb_wd_q;
                bus.wrdata = result;
            end else if (buf_valid_q) begin
                bus.wr_en  = (buf_wd_q != '0);
                bus.wraddr = buf_wd_q;
                bus.wrdata = buf_wdata_q;
            end
        end
    end
endmodule
